tooth_period_capture: RTL and testbench

TOOTH_PERIOD_CAPTURE -- requirements
Module: tooth_period_capture

---
 rtl/hwag_pkg.sv | 14 +
 rtl/tooth_period_capture_cap_filter.sv | 49 ++++
 rtl/tooth_period_capture.sv | 140 ++++++++++++++
 tb/tb_tooth_period_capture.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hwag_pkg.sv
// Shared definitions for the tooth-period capture block.
package hwag_pkg;

    localparam int unsigned DEF_WIDTH  = 24;
    localparam int unsigned DEF_FILTER = 3;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_FIRST  = 2'd1,
        ST_MEASURE_ONE = 2'd2,
        ST_RUN         = 2'd3
    } tpc_state_t;

endpackage

// File: rtl/tooth_period_capture_cap_filter.sv
// Two-flop synchronizer followed by a level filter: the output level only
// follows the synchronized input after FILTER consecutive agreeing samples.
module cap_filter
    import hwag_pkg::*;
#(
    parameter int unsigned FILTER = DEF_FILTER
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level
);

    localparam int unsigned CW = $clog2(FILTER + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous sensor input into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample restarts the count, so only a steady new level gets through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 != level) begin
            if (cnt == CW'(FILTER - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/tooth_period_capture.sv
// Measures the period between accepted active edges of a tooth sensor and
// presents the latest two periods as a pair for a downstream comparator.
module tooth_period_capture
    import hwag_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned FILTER = DEF_FILTER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cap_in,
    input  logic             edge_sel,
    output logic [WIDTH-1:0] period_cur,
    output logic [WIDTH-1:0] period_prev,
    output logic             period_valid,
    output logic             edge_pulse,
    output logic             stall,
    output logic [1:0]       state
);

    tpc_state_t       state_q;
    tpc_state_t       state_n;
    logic             level;
    logic             level_q;
    logic [WIDTH-1:0] timer;
    logic             sat;
    logic             cap_first;
    logic             cap_shift;
    logic             set_stall;

    cap_filter #(.FILTER(FILTER)) u_filter (
        .clk   (clk),
        .rst   (rst),
        .in    (cap_in),
        .level (level)
    );

    // Previous filtered level; runs regardless of FSM state so the first
    // edge seen after enable is a genuine transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= level;
    end

    // Edge strobe derived only from level transitions, so flipping edge_sel
    // on a steady level cannot create a pulse.
    always_comb begin
        edge_pulse = edge_sel ? (level_q & ~level) : (~level_q & level);
    end

    assign sat   = (timer == '1);
    assign state = state_q;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_n;
    end

    // Next-state and capture decisions; an edge takes priority over saturation.
    always_comb begin
        state_n   = state_q;
        cap_first = 1'b0;
        cap_shift = 1'b0;
        set_stall = 1'b0;
        if (!enable) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_n = ST_WAIT_FIRST;
                ST_WAIT_FIRST: begin
                    if (edge_pulse) state_n = ST_MEASURE_ONE;
                end
                ST_MEASURE_ONE: begin
                    if (edge_pulse) begin
                        cap_first = 1'b1;
                        state_n   = ST_RUN;
                    end else if (sat) begin
                        set_stall = 1'b1;
                        state_n   = ST_WAIT_FIRST;
                    end
                end
                ST_RUN: begin
                    if (edge_pulse) begin
                        cap_shift = 1'b1;
                    end else if (sat) begin
                        set_stall = 1'b1;
                        state_n   = ST_WAIT_FIRST;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Period timer: zero in IDLE, parked until the first edge, restarts at 1
    // on every edge and saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (!enable || state_q == ST_IDLE) begin
            timer <= '0;
        end else if (edge_pulse) begin
            timer <= WIDTH'(1);
        end else if (state_q != ST_WAIT_FIRST && !sat) begin
            timer <= timer + 1'b1;
        end
    end

    // Period registers, pair-valid strobe and sticky stall flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cur   <= '0;
            period_prev  <= '0;
            period_valid <= 1'b0;
            stall        <= 1'b0;
        end else if (!enable) begin
            period_cur   <= '0;
            period_prev  <= '0;
            period_valid <= 1'b0;
            stall        <= 1'b0;
        end else begin
            period_valid <= cap_shift;
            if (cap_first) begin
                period_cur <= timer;
            end
            if (cap_shift) begin
                period_prev <= period_cur;
                period_cur  <= timer;
            end
            if (set_stall) begin
                stall <= 1'b1;
            end else if (edge_pulse) begin
                stall <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tooth_period_capture.sv
// Directed bench for tooth_period_capture (WIDTH=8, FILTER=3).
module tb_tooth_period_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       cap_in = 1'b0;
    logic       edge_sel = 1'b0;
    logic [7:0] period_cur;
    logic [7:0] period_prev;
    logic       period_valid;
    logic       edge_pulse;
    logic       stall;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int pv_count = 0;
    logic [7:0] pv_cur = '0;
    logic [7:0] pv_prev = '0;

    tooth_period_capture #(.WIDTH(8), .FILTER(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cap_in       (cap_in),
        .edge_sel     (edge_sel),
        .period_cur   (period_cur),
        .period_prev  (period_prev),
        .period_valid (period_valid),
        .edge_pulse   (edge_pulse),
        .stall        (stall),
        .state        (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one clock and sample just after the edge; record valid pairs.
    task automatic tick;
        @(posedge clk);
        #1;
        if (period_valid === 1'b1) begin
            pv_count++;
            pv_cur  = period_cur;
            pv_prev = period_prev;
        end
    endtask

    // Rising cap_in now, next rising cap_in 'gap' cycles later.
    task automatic pulse(input int gap);
        cap_in = 1'b1;
        repeat (10) tick;
        cap_in = 1'b0;
        repeat (gap - 10) tick;
    endtask

    task automatic do_reset;
        rst = 1'b1; enable = 1'b0; cap_in = 1'b0; edge_sel = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        pv_count = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (period_cur !== 8'd0) begin errors++; $display("FAIL reset_cur: got %0d expected 0", period_cur); end
        checks++; if (period_prev !== 8'd0) begin errors++; $display("FAIL reset_prev: got %0d expected 0", period_prev); end
        checks++; if ({period_valid, edge_pulse, stall} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {period_valid, edge_pulse, stall}); end
    endtask

    task automatic test_filter;
        int cnt;
        int first;
        do_reset;
        cap_in = 1'b1; tick; tick; cap_in = 1'b0;
        cnt = 0;
        repeat (12) begin tick; if (edge_pulse) cnt++; end
        checks++; if (cnt != 0) begin errors++; $display("FAIL glitch_rejected: got %0d pulses expected 0", cnt); end
        cap_in = 1'b1; cnt = 0; first = 0;
        for (int k = 1; k <= 14; k++) begin
            tick;
            if (k == 4) cap_in = 1'b0;
            if (edge_pulse) begin cnt++; if (first == 0) first = k; end
        end
        checks++; if (first != 5) begin errors++; $display("FAIL rise_latency: got %0d expected 5", first); end
        checks++; if (cnt != 1) begin errors++; $display("FAIL rise_pulse_count: got %0d expected 1", cnt); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_while_disabled: got %0d expected 0", state); end
    endtask

    task automatic test_edge_sel;
        int cnt;
        int first;
        edge_sel = 1'b1; cnt = 0;
        repeat (8) begin tick; if (edge_pulse) cnt++; end
        checks++; if (cnt != 0) begin errors++; $display("FAIL sel_change_low: got %0d pulses expected 0", cnt); end
        cap_in = 1'b1; cnt = 0;
        repeat (10) begin tick; if (edge_pulse) cnt++; end
        checks++; if (cnt != 0) begin errors++; $display("FAIL rise_ignored_falling_sel: got %0d pulses expected 0", cnt); end
        edge_sel = 1'b0; cnt = 0;
        repeat (6) begin tick; if (edge_pulse) cnt++; end
        checks++; if (cnt != 0) begin errors++; $display("FAIL sel_change_high: got %0d pulses expected 0", cnt); end
        edge_sel = 1'b1; cap_in = 1'b0; first = 0;
        for (int k = 1; k <= 10; k++) begin tick; if (edge_pulse && first == 0) first = k; end
        checks++; if (first != 5) begin errors++; $display("FAIL fall_latency: got %0d expected 5", first); end
        edge_sel = 1'b0;
        repeat (3) tick;
    endtask

    task automatic test_periods;
        do_reset;
        enable = 1'b1; tick;
        pulse(100); pulse(100);
        checks++; if (pv_count != 0) begin errors++; $display("FAIL no_valid_two_edges: got %0d expected 0", pv_count); end
        pulse(100);
        checks++; if (pv_count != 1) begin errors++; $display("FAIL valid_third_edge: got %0d expected 1", pv_count); end
        checks++; if (pv_cur !== 8'd100 || pv_prev !== 8'd100) begin errors++; $display("FAIL pair_100_100: got %0d/%0d expected 100/100", pv_cur, pv_prev); end
        pulse(33); pulse(20);
        checks++; if (pv_count != 3) begin errors++; $display("FAIL valid_count_run: got %0d expected 3", pv_count); end
        checks++; if (pv_cur !== 8'd33 || pv_prev !== 8'd100) begin errors++; $display("FAIL pair_33_100: got %0d/%0d expected 33/100", pv_cur, pv_prev); end
    endtask

    task automatic test_stall;
        bit found;
        do_reset;
        enable = 1'b1; tick;
        cap_in = 1'b1; found = 0;
        for (int k = 0; k < 10 && !found; k++) begin tick; if (edge_pulse) found = 1; end
        checks++; if (!found) begin errors++; $display("FAIL first_edge_timeout: got none expected edge"); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL wait_first_at_edge: got %0d expected 1", state); end
        for (int i = 1; i <= 256; i++) begin
            tick;
            if (i == 255) begin
                checks++; if (state !== 2'd2 || stall !== 1'b0) begin errors++; $display("FAIL before_sat: got state %0d stall %0b expected 2 0", state, stall); end
            end
        end
        checks++; if (state !== 2'd1 || stall !== 1'b1) begin errors++; $display("FAIL stall_m1: got state %0d stall %0b expected 1 1", state, stall); end
        cap_in = 1'b0; repeat (8) tick; cap_in = 1'b1; found = 0;
        for (int k = 0; k < 10 && !found; k++) begin tick; if (edge_pulse) found = 1; end
        checks++; if (!found) begin errors++; $display("FAIL restart_edge_timeout: got none expected edge"); end
        tick;
        checks++; if (state !== 2'd2 || stall !== 1'b0) begin errors++; $display("FAIL stall_cleared: got state %0d stall %0b expected 2 0", state, stall); end
        repeat (9) tick; cap_in = 1'b0; repeat (240) tick; cap_in = 1'b1; repeat (5) tick;
        checks++; if (edge_pulse !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL edge_at_sat: got edge %0b state %0d expected 1 2", edge_pulse, state); end
        tick;
        checks++; if (state !== 2'd3 || stall !== 1'b0 || period_cur !== 8'd255) begin errors++; $display("FAIL capture_255: got state %0d stall %0b cur %0d expected 3 0 255", state, stall, period_cur); end
        repeat (254) tick;
        checks++; if (state !== 2'd3 || stall !== 1'b0) begin errors++; $display("FAIL run_before_sat: got state %0d stall %0b expected 3 0", state, stall); end
        tick;
        checks++; if (state !== 2'd1 || stall !== 1'b1) begin errors++; $display("FAIL stall_run: got state %0d stall %0b expected 1 1", state, stall); end
        checks++; if (period_cur !== 8'd255 || period_prev !== 8'd0) begin errors++; $display("FAIL periods_kept: got %0d/%0d expected 255/0", period_cur, period_prev); end
        checks++; if (pv_count != 0) begin errors++; $display("FAIL no_valid_stall: got %0d expected 0", pv_count); end
    endtask

    task automatic test_enable_drop;
        bit found;
        do_reset;
        enable = 1'b1; tick;
        pulse(100); pulse(100); pulse(100);
        checks++; if (period_cur !== 8'd100 || pv_count != 1) begin errors++; $display("FAIL before_drop: got cur %0d valids %0d expected 100 1", period_cur, pv_count); end
        cap_in = 1'b1; found = 0;
        for (int k = 0; k < 10 && !found; k++) begin tick; if (edge_pulse) found = 1; end
        checks++; if (!found) begin errors++; $display("FAIL drop_edge_timeout: got none expected edge"); end
        enable = 1'b0;
        tick;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL drop_idle: got %0d expected 0", state); end
        checks++; if (period_cur !== 8'd0 || period_prev !== 8'd0) begin errors++; $display("FAIL drop_clear: got %0d/%0d expected 0/0", period_cur, period_prev); end
        checks++; if (period_valid !== 1'b0 || pv_count != 1) begin errors++; $display("FAIL drop_suppress: got valid %0b count %0d expected 0 1", period_valid, pv_count); end
        cap_in = 1'b0; repeat (10) tick;
        enable = 1'b1; tick;
        pulse(50); pulse(50);
        checks++; if (pv_count != 1) begin errors++; $display("FAIL reenable_two_edges: got %0d expected 1", pv_count); end
        pulse(50);
        checks++; if (pv_count != 2 || pv_cur !== 8'd50 || pv_prev !== 8'd50) begin errors++; $display("FAIL reenable_pair: got count %0d %0d/%0d expected 2 50/50", pv_count, pv_cur, pv_prev); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        enable = 1'b1; tick;
        pulse(100); pulse(100);
        checks++; if (period_cur !== 8'd100 || state !== 2'd3) begin errors++; $display("FAIL pre_reset: got cur %0d state %0d expected 100 3", period_cur, state); end
        repeat (20) tick;
        #3 rst = 1'b1;
        #1;
        checks++; if (state !== 2'd0 || period_cur !== 8'd0 || period_prev !== 8'd0) begin errors++; $display("FAIL async_reset_regs: got state %0d cur %0d prev %0d expected 0 0 0", state, period_cur, period_prev); end
        checks++; if ({period_valid, edge_pulse, stall} !== 3'b000) begin errors++; $display("FAIL async_reset_flags: got %b expected 000", {period_valid, edge_pulse, stall}); end
        tick; rst = 1'b0; pv_count = 0;
        tick;
        pulse(60); pulse(60);
        checks++; if (pv_count != 0) begin errors++; $display("FAIL post_reset_two_edges: got %0d expected 0", pv_count); end
        pulse(60);
        checks++; if (pv_count != 1 || pv_cur !== 8'd60 || pv_prev !== 8'd60) begin errors++; $display("FAIL post_reset_pair: got count %0d %0d/%0d expected 1 60/60", pv_count, pv_cur, pv_prev); end
    endtask

    initial begin
        test_reset;
        test_filter;
        test_edge_sel;
        test_periods;
        test_stall;
        test_enable_drop;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
